// File: rtl/tow_referee.sv
`default_nettype none
// ============================================================================
//  Module   : tow_referee
//  Purpose  : Tug-of-war game sequencer. Samples the push-button lockout
//             latch (push/tie/right), moves the rope one step per won push,
//             drives the latch clear, enforces a clean button release before
//             each round and declares a winner at either end of the field.
//  Options  : `define TOW_MATCH_SCORE_EN adds saturating per-side match
//             counters (score_l / score_r) that only reset clears.
//  Revision : 1.0  initial release
// ============================================================================
module tow_referee #(
    parameter int HALF_FIELD  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int POS_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pbl,
    input  logic             pbr,
    input  logic             push,
    input  logic             tie,
    input  logic             right,
    input  logic             new_game,
    output logic             clr,
    output logic [POS_W-1:0] pos,
    output logic             win_l,
    output logic             win_r,
`ifdef TOW_MATCH_SCORE_EN
    output logic [3:0]       score_l,
    output logic [3:0]       score_r,
`endif
    output logic             busy
);

    // Field geometry and hold-off terminal count.
    localparam logic [POS_W-1:0] c_centre    = POS_W'(HALF_FIELD);
    localparam logic [POS_W-1:0] c_max_pos   = POS_W'(2 * HALF_FIELD);
    localparam logic [7:0]       c_hold_last = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        ARMED = 2'd1,
        SCORE = 2'd2,
        WIN   = 2'd3
    } state_t;

    // Synchroniser bit order: {pbr, pbl, right, tie, push}.
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] w_raw;

    logic       w_push_s;
    logic       w_tie_s;
    logic       w_right_s;
    logic       w_btn_s;

    state_t           r_state;
    state_t           w_state_nx;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_pos_nx;
    logic [POS_W-1:0] w_pos_new;
    logic             r_win_l;
    logic             w_win_l_nx;
    logic             r_win_r;
    logic             w_win_r_nx;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nx;
`ifdef TOW_MATCH_SCORE_EN
    logic [3:0]       r_score_l;
    logic [3:0]       w_score_l_nx;
    logic [3:0]       r_score_r;
    logic [3:0]       w_score_r_nx;
`endif

    assign w_raw     = {pbr, pbl, right, tie, push};
    assign w_push_s  = r_sync2[0];
    assign w_tie_s   = r_sync2[1];
    assign w_right_s = r_sync2[2];
    // Either raw button still pressed blocks the release count.
    assign w_btn_s   = r_sync2[3] | r_sync2[4];

    // Two-flop synchronisers for all asynchronous latch and button inputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // State and game registers; reset lands in HOLD with the rope centred.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= HOLD;
            r_pos   <= c_centre;
            r_win_l <= 1'b0;
            r_win_r <= 1'b0;
            r_cnt   <= '0;
`ifdef TOW_MATCH_SCORE_EN
            r_score_l <= '0;
            r_score_r <= '0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_pos   <= w_pos_nx;
            r_win_l <= w_win_l_nx;
            r_win_r <= w_win_r_nx;
            r_cnt   <= w_cnt_nx;
`ifdef TOW_MATCH_SCORE_EN
            r_score_l <= w_score_l_nx;
            r_score_r <= w_score_r_nx;
`endif
        end
    end

    // Next-state and datapath decisions; new_game outranks every transition.
    always_comb begin
        w_state_nx = r_state;
        w_pos_nx   = r_pos;
        w_win_l_nx = r_win_l;
        w_win_r_nx = r_win_r;
        w_cnt_nx   = r_cnt;
        w_pos_new  = r_pos;
`ifdef TOW_MATCH_SCORE_EN
        w_score_l_nx = r_score_l;
        w_score_r_nx = r_score_r;
`endif

        // Rope step for the current latch result, clamped to the field.
        if (!w_tie_s) begin
            if (w_right_s) begin
                w_pos_new = (r_pos == c_max_pos) ? r_pos : r_pos + 1'b1;
            end else begin
                w_pos_new = (r_pos == '0) ? r_pos : r_pos - 1'b1;
            end
        end

        if (new_game) begin
            w_state_nx = HOLD;
            w_pos_nx   = c_centre;
            w_win_l_nx = 1'b0;
            w_win_r_nx = 1'b0;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (w_btn_s) begin
                        w_cnt_nx = '0;
                    end else if (r_cnt == c_hold_last) begin
                        w_cnt_nx   = '0;
                        w_state_nx = ARMED;
                    end else begin
                        w_cnt_nx = r_cnt + 8'd1;
                    end
                end
                ARMED: begin
                    // A tie without push is not a real result; only push counts.
                    if (w_push_s) begin
                        w_state_nx = SCORE;
                    end
                end
                SCORE: begin
                    w_pos_nx = w_pos_new;
                    w_cnt_nx = '0;
                    if (w_pos_new == '0) begin
                        w_state_nx = WIN;
                        w_win_l_nx = 1'b1;
`ifdef TOW_MATCH_SCORE_EN
                        w_score_l_nx = (r_score_l == 4'hF) ? 4'hF : r_score_l + 4'd1;
`endif
                    end else if (w_pos_new == c_max_pos) begin
                        w_state_nx = WIN;
                        w_win_r_nx = 1'b1;
`ifdef TOW_MATCH_SCORE_EN
                        w_score_r_nx = (r_score_r == 4'hF) ? 4'hF : r_score_r + 4'd1;
`endif
                    end else begin
                        w_state_nx = HOLD;
                    end
                end
                WIN: begin
                    // Frozen until new_game or reset.
                    w_state_nx = WIN;
                end
                default: begin
                    w_state_nx = HOLD;
                end
            endcase
        end
    end

    // Latch is held clear everywhere except while waiting for a press.
    assign clr   = (r_state != ARMED);
    assign busy  = (r_state != ARMED);
    assign pos   = r_pos;
    assign win_l = r_win_l;
    assign win_r = r_win_r;
`ifdef TOW_MATCH_SCORE_EN
    assign score_l = r_score_l;
    assign score_r = r_score_r;
`endif

endmodule
`default_nettype wire
